booth_seq_multiplier: RTL

- Sequential radix-2 Booth multiplier controller.
- Sits directly upstream of the combinational Booth step datapath.
- Holds the accumulator A, multiplier Q and Q_1 registers, feeds them to one step instance per clock, and iterates WIDTH times.
- Produces a 2*WIDTH-bit signed product with a start/done handshake for the surrounding ALU.

---
 rtl/booth_pkg.sv | 19 +
 rtl/booth_step_unit.sv | 37 +++
 rtl/booth_seq_multiplier.sv | 119 +++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
// Optional feature macro: BOOTH_ZERO_BYPASS_EN (see booth_seq_multiplier.sv).
package booth_pkg;

    // Operand width used when the parent does not override WIDTH
    localparam int BOOTH_DEFAULT_WIDTH = 32;

    // Encodings of {Q[0], Q_1} that trigger an add or a subtract
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_e;

endpackage

// File: rtl/booth_step_unit.sv
// One combinational radix-2 Booth iteration: add/subtract M into A, then
// arithmetic shift right of {A, Q, Q_1}.
module booth_step_unit
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mplier_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic             qMinus1_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mplier_o,
    output logic             qMinus1_o
);

    logic [WIDTH:0] accExt;
    logic [WIDTH:0] mcandExt;
    logic [WIDTH:0] sumExt;

    // The sum is formed one bit wider than A so that A-M with M at the most
    // negative value keeps its true sign; the shift then brings it back to
    // WIDTH bits without loss, and any carry beyond that bit is dropped.
    always_comb begin
        accExt   = {acc_i[WIDTH-1], acc_i};
        mcandExt = {mcand_i[WIDTH-1], mcand_i};
        case ({mplier_i[0], qMinus1_i})
            BOOTH_ADD: sumExt = accExt + mcandExt;
            BOOTH_SUB: sumExt = accExt + ~mcandExt + (WIDTH+1)'(1);
            default:   sumExt = accExt;
        endcase
        acc_o     = sumExt[WIDTH:1];
        mplier_o  = {sumExt[0], mplier_i[WIDTH-1:1]};
        qMinus1_o = mplier_i[0];
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier controller with start/done handshake.
// Owns the A, Q, M, Q_1 registers and the iteration counter; one
// booth_step_unit performs each iteration.
// Optional feature macro: BOOTH_ZERO_BYPASS_EN -- when defined, a zero
// operand skips the iterations and completes one cycle after accept.
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    booth_state_e       state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   mcand_q;
    logic               qMinus1_q;
    logic [CNT_W-1:0]   count_q;
    logic [2*WIDTH-1:0] product_q;
    logic               done_q;
    logic               busy_q;
    logic               ready_q;

    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   mplier_d;
    logic               qMinus1_d;
    logic               zeroOperand;

`ifdef BOOTH_ZERO_BYPASS_EN
    assign zeroOperand = (multiplicand == '0) || (multiplier == '0);
`else
    assign zeroOperand = 1'b0;
`endif

    booth_step_unit #(
        .WIDTH(WIDTH)
    ) stepUnit (
        .acc_i     (acc_q),
        .mplier_i  (mplier_q),
        .mcand_i   (mcand_q),
        .qMinus1_i (qMinus1_q),
        .acc_o     (acc_d),
        .mplier_o  (mplier_d),
        .qMinus1_o (qMinus1_d)
    );

    // Controller FSM: accept in IDLE/DONE, iterate WIDTH times in RUN, pulse done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            qMinus1_q <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q   <= multiplicand;
                        qMinus1_q <= 1'b0;
                        acc_q     <= '0;
                        count_q   <= CNT_W'(WIDTH);
                        if (zeroOperand) begin
                            mplier_q  <= '0;
                            product_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            mplier_q <= multiplier;
                            busy_q   <= 1'b1;
                            ready_q  <= 1'b0;
                            state_q  <= RUN;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q     <= acc_d;
                    mplier_q  <= mplier_d;
                    qMinus1_q <= qMinus1_d;
                    count_q   <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        product_q <= {acc_d, mplier_d};
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        ready_q   <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
